// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with one-bubble RAW stall control for a core that forwards only from MEM/WB.
// Optional HAZARD_STALL_CNT_EN adds a free-running count of hazard stalls on stall_count.
module id_ex_hazard_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [XLEN-1:0]   id_pc,
    input  logic              flush,
    input  logic              mem_busy,
    output logic              ID_EX_valid,
    output logic              ID_EX_RegWrite,
    output logic              ID_EX_MemRead,
    output logic              ID_EX_MemWrite,
    output logic [4:0]        ID_EX_RegisterRs1,
    output logic [4:0]        ID_EX_RegisterRs2,
    output logic [4:0]        ID_EX_RegisterRd,
    output logic [CTRL_W-1:0] ID_EX_ctrl,
    output logic [XLEN-1:0]   ID_EX_rs1_data,
    output logic [XLEN-1:0]   ID_EX_rs2_data,
    output logic [XLEN-1:0]   ID_EX_imm,
    output logic [XLEN-1:0]   ID_EX_pc,
    output logic              stall_if_id,
    output logic              hazard
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0]       stall_count
`endif
);

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } stageState_t;

    stageState_t stateQ, stateNext;
    logic        matchRs1, matchRs2, raw;
    logic        loadBubble, hazardStall;

    assign matchRs1 = id_uses_rs1 && (id_rs1 == ID_EX_RegisterRd);
    assign matchRs2 = id_uses_rs2 && (id_rs2 == ID_EX_RegisterRd);
    assign raw      = id_valid && ID_EX_valid && ID_EX_RegWrite &&
                      (ID_EX_RegisterRd != 5'd0) && (matchRs1 || matchRs2);

    // Priority: memory freeze, then branch flush, then hazard bubble, then normal capture.
    always_comb begin
        stateNext   = stateQ;
        loadBubble  = 1'b0;
        hazardStall = 1'b0;
        stall_if_id = 1'b0;
        hazard      = raw && (stateQ == RUN);
        if (mem_busy) begin
            stall_if_id = 1'b1;
        end else if (flush) begin
            loadBubble = 1'b1;
            stateNext  = RUN;
        end else if (hazard) begin
            loadBubble  = 1'b1;
            hazardStall = 1'b1;
            stall_if_id = 1'b1;
            stateNext   = BUBBLE;
        end else begin
            stateNext = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= RUN;
        end else begin
            stateQ <= stateNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ID_EX_valid       <= 1'b0;
            ID_EX_RegWrite    <= 1'b0;
            ID_EX_MemRead     <= 1'b0;
            ID_EX_MemWrite    <= 1'b0;
            ID_EX_RegisterRs1 <= '0;
            ID_EX_RegisterRs2 <= '0;
            ID_EX_RegisterRd  <= '0;
            ID_EX_ctrl        <= '0;
            ID_EX_rs1_data    <= '0;
            ID_EX_rs2_data    <= '0;
            ID_EX_imm         <= '0;
            ID_EX_pc          <= '0;
        end else if (!mem_busy) begin
            if (loadBubble) begin
                ID_EX_valid       <= 1'b0;
                ID_EX_RegWrite    <= 1'b0;
                ID_EX_MemRead     <= 1'b0;
                ID_EX_MemWrite    <= 1'b0;
                ID_EX_RegisterRs1 <= '0;
                ID_EX_RegisterRs2 <= '0;
                ID_EX_RegisterRd  <= '0;
                ID_EX_ctrl        <= '0;
                ID_EX_rs1_data    <= '0;
                ID_EX_rs2_data    <= '0;
                ID_EX_imm         <= '0;
                ID_EX_pc          <= '0;
            end else begin
                ID_EX_valid       <= id_valid;
                ID_EX_RegWrite    <= id_regwrite && id_valid;
                ID_EX_MemRead     <= id_memread && id_valid;
                ID_EX_MemWrite    <= id_memwrite && id_valid;
                ID_EX_RegisterRs1 <= id_rs1;
                ID_EX_RegisterRs2 <= id_rs2;
                ID_EX_RegisterRd  <= id_rd;
                ID_EX_ctrl        <= id_ctrl & {CTRL_W{id_valid}};
                ID_EX_rs1_data    <= id_rs1_data;
                ID_EX_rs2_data    <= id_rs2_data;
                ID_EX_imm         <= id_imm;
                ID_EX_pc          <= id_pc;
            end
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= 32'd0;
        end else if (hazardStall) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`else
    logic unusedHazardStall;
    assign unusedHazardStall = hazardStall;
`endif

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench for id_ex_hazard_stage: stalls, x0/unused-rs filtering, flush, mem_busy freeze, chains, reset.
// Build with +define+HAZARD_STALL_CNT_EN to also check stall_count.
module tb_id_ex_hazard_stage;

    logic        clk, rst;
    logic        id_valid, id_uses_rs1, id_uses_rs2;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_regwrite, id_memread, id_memwrite;
    logic [7:0]  id_ctrl;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic        flush, mem_busy;
    logic        ID_EX_valid, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite;
    logic [4:0]  ID_EX_RegisterRs1, ID_EX_RegisterRs2, ID_EX_RegisterRd;
    logic [7:0]  ID_EX_ctrl;
    logic [31:0] ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm, ID_EX_pc;
    logic        stall_if_id, hazard;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_count;
`endif

    int checks = 0;
    int errors = 0;

    id_ex_hazard_stage #(.XLEN(32), .CTRL_W(8)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_ctrl(id_ctrl), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_pc(id_pc), .flush(flush), .mem_busy(mem_busy),
        .ID_EX_valid(ID_EX_valid), .ID_EX_RegWrite(ID_EX_RegWrite),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MemWrite(ID_EX_MemWrite),
        .ID_EX_RegisterRs1(ID_EX_RegisterRs1), .ID_EX_RegisterRs2(ID_EX_RegisterRs2),
        .ID_EX_RegisterRd(ID_EX_RegisterRd), .ID_EX_ctrl(ID_EX_ctrl),
        .ID_EX_rs1_data(ID_EX_rs1_data), .ID_EX_rs2_data(ID_EX_rs2_data),
        .ID_EX_imm(ID_EX_imm), .ID_EX_pc(ID_EX_pc),
        .stall_if_id(stall_if_id), .hazard(hazard)
`ifdef HAZARD_STALL_CNT_EN
        , .stall_count(stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Operand payloads are derived from the PC so every capture check can rebuild them.
    task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic u1, input logic u2,
                                 input logic rw, input logic mr, input logic mw, input logic [31:0] pc);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_uses_rs1 = u1;
        id_uses_rs2 = u2;
        id_regwrite = rw;
        id_memread  = mr;
        id_memwrite = mw;
        id_pc       = pc;
        id_rs1_data = pc ^ 32'hA5A5_0000;
        id_rs2_data = pc ^ 32'h5A5A_0000;
        id_imm      = pc + 32'd4;
        id_ctrl     = pc[9:2];
        #1;
    endtask

    task automatic clockEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic checkCaptured(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic rw, input logic mr, input logic [31:0] pc);
        checkOutput({tag, ".valid"}, 32'(ID_EX_valid), 32'd1);
        checkOutput({tag, ".rs1"}, 32'(ID_EX_RegisterRs1), 32'(rs1));
        checkOutput({tag, ".rs2"}, 32'(ID_EX_RegisterRs2), 32'(rs2));
        checkOutput({tag, ".rd"}, 32'(ID_EX_RegisterRd), 32'(rd));
        checkOutput({tag, ".regwrite"}, 32'(ID_EX_RegWrite), 32'(rw));
        checkOutput({tag, ".memread"}, 32'(ID_EX_MemRead), 32'(mr));
        checkOutput({tag, ".pc"}, ID_EX_pc, pc);
        checkOutput({tag, ".rs1data"}, ID_EX_rs1_data, pc ^ 32'hA5A5_0000);
        checkOutput({tag, ".rs2data"}, ID_EX_rs2_data, pc ^ 32'h5A5A_0000);
        checkOutput({tag, ".imm"}, ID_EX_imm, pc + 32'd4);
        checkOutput({tag, ".ctrl"}, 32'(ID_EX_ctrl), 32'(pc[9:2]));
    endtask

    task automatic checkBubble(input string tag);
        checkOutput({tag, ".valid"}, 32'(ID_EX_valid), 32'd0);
        checkOutput({tag, ".regwrite"}, 32'(ID_EX_RegWrite), 32'd0);
        checkOutput({tag, ".memread"}, 32'(ID_EX_MemRead), 32'd0);
        checkOutput({tag, ".memwrite"}, 32'(ID_EX_MemWrite), 32'd0);
    endtask

    task automatic checkStall(input string tag, input logic expStall, input logic expHazard);
        checkOutput({tag, ".stall"}, 32'(stall_if_id), 32'(expStall));
        checkOutput({tag, ".hazard"}, 32'(hazard), 32'(expHazard));
    endtask

    task automatic checkCount(input string tag, input logic [31:0] expected);
`ifdef HAZARD_STALL_CNT_EN
        checkOutput({tag, ".stall_count"}, stall_count, expected);
`else
        if (expected == 32'hFFFF_FFFF) $display("[TB] %s unused", tag);
`endif
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        mem_busy = 1'b0;
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #11;
        checkBubble("reset");
        checkOutput("reset.rd", 32'(ID_EX_RegisterRd), 32'd0);
        checkOutput("reset.pc", ID_EX_pc, 32'd0);
        checkStall("reset", 1'b0, 1'b0);
        checkCount("reset", 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] ALU-use hazard on rs2");
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100);
        checkStall("addX5", 1'b0, 1'b0);
        clockEdge();
        checkCaptured("addX5", 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 32'h100);
        applyStimulus(1'b1, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h104);
        checkStall("subHaz", 1'b1, 1'b1);
        clockEdge();
        checkBubble("subBubble");
        checkStall("subBubble", 1'b0, 1'b0);
        checkCount("afterSub", 32'd1);
        clockEdge();
        checkCaptured("subCap", 5'd4, 5'd5, 5'd6, 1'b1, 1'b0, 32'h104);

        $display("[TB] x0 destination and unused rs");
        applyStimulus(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h108);
        checkStall("lwX0", 1'b0, 1'b0);
        clockEdge();
        checkCaptured("lwX0", 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 32'h108);
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10C);
        checkStall("readX0", 1'b0, 1'b0);
        clockEdge();
        checkCaptured("addX7", 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 32'h10C);
        applyStimulus(1'b1, 5'd7, 5'd3, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h110);
        checkStall("unusedRs1", 1'b0, 1'b0);
        clockEdge();
        checkCaptured("unusedRs1", 5'd7, 5'd3, 5'd8, 1'b1, 1'b0, 32'h110);

        $display("[TB] flush with a pending hazard");
        applyStimulus(1'b1, 5'd8, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h114);
        flush = 1'b1;
        #1;
        checkOutput("flush.stall", 32'(stall_if_id), 32'd0);
        clockEdge();
        flush = 1'b0;
        checkBubble("flushBubble");
        checkCount("afterFlush", 32'd1);
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h200);
        checkStall("postFlush", 1'b0, 1'b0);
        clockEdge();
        checkCaptured("addX3", 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h200);

        $display("[TB] mem_busy freeze");
        applyStimulus(1'b1, 5'd3, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h204);
        mem_busy = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("busy.stall", 32'(stall_if_id), 32'd1);
            clockEdge();
            checkCaptured("busyHold", 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h200);
        end
        checkCount("afterBusy", 32'd1);
        mem_busy = 1'b0;
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h204);
        checkStall("busyRelease", 1'b0, 1'b0);
        clockEdge();
        checkCaptured("addX9", 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 32'h204);

        $display("[TB] dependency chain x1 -> x2 -> x3");
        applyStimulus(1'b1, 5'd10, 5'd11, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h300);
        checkStall("chainA", 1'b0, 1'b0);
        clockEdge();
        checkCaptured("chainA", 5'd10, 5'd11, 5'd1, 1'b1, 1'b0, 32'h300);
        applyStimulus(1'b1, 5'd1, 5'd12, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h304);
        checkStall("chainB", 1'b1, 1'b1);
        clockEdge();
        checkBubble("chainBubble1");
        checkStall("chainBheld", 1'b0, 1'b0);
        clockEdge();
        checkCaptured("chainB", 5'd1, 5'd12, 5'd2, 1'b1, 1'b0, 32'h304);
        applyStimulus(1'b1, 5'd13, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h308);
        checkStall("chainC", 1'b1, 1'b1);
        clockEdge();
        checkBubble("chainBubble2");
        clockEdge();
        checkCaptured("chainC", 5'd13, 5'd2, 5'd3, 1'b1, 1'b0, 32'h308);
        checkCount("afterChain", 32'd3);

        $display("[TB] reset during bubble");
        applyStimulus(1'b1, 5'd3, 5'd0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h400);
        checkStall("preReset", 1'b1, 1'b1);
        clockEdge();
        rst = 1'b1;
        #1;
        checkBubble("midReset");
        checkOutput("midReset.rd", 32'(ID_EX_RegisterRd), 32'd0);
        checkOutput("midReset.pc", ID_EX_pc, 32'd0);
        checkOutput("midReset.ctrl", 32'(ID_EX_ctrl), 32'd0);
        checkStall("midReset", 1'b0, 1'b0);
        checkCount("midReset", 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkStall("postReset", 1'b0, 1'b0);
        clockEdge();
        checkCaptured("postReset", 5'd3, 5'd0, 5'd12, 1'b1, 1'b0, 32'h400);

        $display("[TB] invalid slot gating and RUN after reset");
        applyStimulus(1'b0, 5'd12, 5'd0, 5'd14, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h404);
        checkStall("invalidId", 1'b0, 1'b0);
        clockEdge();
        checkBubble("invalidCap");
        checkOutput("invalidCap.ctrl", 32'(ID_EX_ctrl), 32'd0);
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h408);
        clockEdge();
        applyStimulus(1'b1, 5'd12, 5'd0, 5'd15, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40C);
        checkStall("runAfterReset", 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        errors++;
        $display("[TB] FAIL timeout: observed=running expected=finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/id_ex_hazard_stage.md
Name: id_ex_hazard_stage

Overview:
ID/EX pipeline register of the 5-stage RV32I core, with load/ALU-use hazard stall control. The datapath forwards only from MEM/WB; there is no EX/MEM path. This block therefore detects a decode instruction that reads the rd of the instruction currently in EX, and inserts exactly one bubble. After the bubble, the MEM/WB forwarding unit downstream covers the dependency. Its ID/EX outputs feed the EX stage and the forwarding unit's rs1/rs2 compare.

Parameters:
XLEN, 32, operand/PC/immediate width
CTRL_W, 8, width of opaque EX/MEM/WB control bundle passed through

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  IF/ID holds a real instruction
id_rs1, id_rs2, id_rd  in  5 each  decoded register indices
id_uses_rs1, id_uses_rs2  in  1 each  instruction actually reads rs1/rs2
id_regwrite, id_memread, id_memwrite  in  1 each  decoded controls
id_ctrl  in  CTRL_W  remaining control bundle
id_rs1_data, id_rs2_data, id_imm, id_pc  in  XLEN each  decode operands
flush  in  1  taken branch/jump resolved in EX; kill instruction in ID
mem_busy  in  1  data memory not ready; freeze whole pipe
ID_EX_valid, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite  out  1 each
ID_EX_RegisterRs1, ID_EX_RegisterRs2, ID_EX_RegisterRd  out  5 each
ID_EX_ctrl  out  CTRL_W
ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm, ID_EX_pc  out  XLEN each
stall_if_id  out  1  hold PC and IF/ID (combinational)
hazard  out  1  RAW hazard detected this cycle (combinational)

Behaviour:
- Reset: asynchronous, active-high. All ID_EX_* outputs clear to 0, including valid. FSM goes to RUN. Reset mid-stall abandons the stall.
- raw = id_valid & ID_EX_valid & ID_EX_RegWrite & (ID_EX_RegisterRd != 0) & ((id_uses_rs1 & id_rs1 == ID_EX_RegisterRd) | (id_uses_rs2 & id_rs2 == ID_EX_RegisterRd)). Loads and ALU ops are treated identically.
- FSM states: RUN, BUBBLE.
- Per-edge priority, highest first:
  1. mem_busy: hold all ID/EX registers and the FSM state; stall_if_id=1. A flush arriving during mem_busy is held by its source until mem_busy is low.
  2. flush: load a bubble (valid, RegWrite, MemRead and MemWrite = 0; other fields don't-care, driven 0). Next state RUN. stall_if_id=0.
  3. RUN & raw: load a bubble; stall_if_id=1, hazard=1. Next state BUBBLE.
  4. Otherwise: capture id_* into ID/EX, with valid=id_valid and controls gated by id_valid. Next state RUN.
- BUBBLE: ID/EX holds the bubble, so raw=0. The stalled instruction is captured normally and the FSM returns to RUN. Total stall is exactly 1 cycle per hazard.
- hazard and stall_if_id are combinational from the current state and inputs, valid in the same cycle as the decision.
- x0 as rd never causes a stall. rs fields with uses=0 never cause a stall.
- Back-to-back dependents (A→B→C chain): each link stalls once, with no lost or duplicated instructions.

Optional Feature:
HAZARD_STALL_CNT_EN:
- Defined: adds output stall_count [31:0], reset to 0. It increments by 1 on every edge where rule 3 fires, and wraps at 2^32−1 → 0. mem_busy and flush cycles are not counted.
- Undefined: port and counter are absent, with no other change.

Test Plan:
- Reset asserted mid-BUBBLE → next sample shows all outputs 0 and FSM in RUN. After deassert, the next instruction is captured with no stall.
- EX: add x5 (RegWrite=1, valid); ID: sub reads x5 via rs2 → hazard=1 and stall_if_id=1 for one cycle, then ID_EX_valid=0. Next cycle: sub captured with ID_EX_RegisterRs2=5, stall_if_id=0.
- EX: lw x0; ID: reads x0 → no stall. EX: add x7; ID: instruction with id_uses_rs1=0 and id_rs1=7 → no stall.
- Hazard present and flush=1 in the same cycle → bubble loaded, stall_if_id=0, FSM in RUN. The next ID instruction is captured directly.
- mem_busy=1 for 3 cycles while ID_EX holds add x3 → ID_EX contents unchanged and stall_if_id=1 throughout. After release, normal flow resumes; with HAZARD_STALL_CNT_EN, stall_count is unchanged.
- Chain add x1; add x2,x1; add x3,x2 issued consecutively → exactly 2 bubbles, all three instructions reach EX in order. With HAZARD_STALL_CNT_EN, stall_count=2.
